// File: rtl/alu_pkg.sv
// Shared opcode encodings for the 8051-compatible ALU and the instruction decoder.
package alu_pkg;
   localparam int ALU_OP_W = 5;

   localparam logic [ALU_OP_W-1:0] ALU_ADD  = 5'd0;
   localparam logic [ALU_OP_W-1:0] ALU_ADDC = 5'd1;
   localparam logic [ALU_OP_W-1:0] ALU_INC  = 5'd2;
   localparam logic [ALU_OP_W-1:0] ALU_DEC  = 5'd3;
   localparam logic [ALU_OP_W-1:0] ALU_SUBB = 5'd4;
   localparam logic [ALU_OP_W-1:0] ALU_MUL  = 5'd5;
   localparam logic [ALU_OP_W-1:0] ALU_DIV  = 5'd6;
   localparam logic [ALU_OP_W-1:0] ALU_DA   = 5'd7;
   localparam logic [ALU_OP_W-1:0] ALU_ANL  = 5'd8;
   localparam logic [ALU_OP_W-1:0] ALU_ORL  = 5'd9;
   localparam logic [ALU_OP_W-1:0] ALU_XRL  = 5'd10;
   localparam logic [ALU_OP_W-1:0] ALU_CLR  = 5'd11;
   localparam logic [ALU_OP_W-1:0] ALU_CPLC = 5'd12;
   localparam logic [ALU_OP_W-1:0] ALU_CPLA = 5'd13;
   localparam logic [ALU_OP_W-1:0] ALU_RL   = 5'd14;
   localparam logic [ALU_OP_W-1:0] ALU_RLC  = 5'd15;
   localparam logic [ALU_OP_W-1:0] ALU_RR   = 5'd16;
   localparam logic [ALU_OP_W-1:0] ALU_RRC  = 5'd17;
   localparam logic [ALU_OP_W-1:0] ALU_SWAP = 5'd18;
endpackage

// File: rtl/alu_muldiv.sv
// Combinational 8x8 multiply and 8/8 divide; divide by zero yields quot=0xFF, rem=a.
module alu_muldiv (
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic [15:0] prod,
   output logic [7:0]  quot,
   output logic [7:0]  rem,
   output logic        div_zero
);
   assign prod     = {8'h00, a} * {8'h00, b};
   assign div_zero = (b == 8'h00);

   always_comb begin
      if (div_zero) begin
         quot = 8'hFF;
         rem  = a;
      end else begin
         quot = a / b;
         rem  = a % b;
      end
   end
endmodule

// File: rtl/alu.sv
// 8-bit 8051 ALU: decodes alu_op into result, flags and B byte, all registered once.
module alu
   import alu_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          a_data,
   input  logic [7:0]          b_data,
   input  logic                c_in,
   input  logic                ac_in,
   input  logic [ALU_OP_W-1:0] alu_op,
   output logic [7:0]          ans,
   output logic                c_out,
   output logic                ac_out,
   output logic                ov_out,
   output logic [7:0]          b_out
);
   logic [15:0] prod;
   logic [7:0]  quot, rem;
   logic        div_zero;

   logic [7:0]  ans_d, b_d;
   logic        c_d, ac_d, ov_d;
   logic [8:0]  sum9, da9;
   logic [4:0]  nib5;

   alu_muldiv u_muldiv (
      .a        (a_data),
      .b        (b_data),
      .prod     (prod),
      .quot     (quot),
      .rem      (rem),
      .div_zero (div_zero)
   );

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      ans_d = 8'h00;
      b_d   = 8'h00;
      c_d   = c_in;
      ac_d  = ac_in;
      ov_d  = 1'b0;
      sum9  = 9'h000;
      nib5  = 5'h00;
      da9   = 9'h000;
      case (alu_op)
         ALU_ADD, ALU_ADDC: begin
            sum9  = {1'b0, a_data} + {1'b0, b_data} + {8'h00, (alu_op == ALU_ADDC) & c_in};
            nib5  = {1'b0, a_data[3:0]} + {1'b0, b_data[3:0]} + {4'h0, (alu_op == ALU_ADDC) & c_in};
            ans_d = sum9[7:0];
            c_d   = sum9[8];
            ac_d  = nib5[4];
            ov_d  = (a_data[7] == b_data[7]) && (sum9[7] != a_data[7]);
         end
         ALU_INC:  ans_d = a_data + 8'h01;
         ALU_DEC:  ans_d = a_data - 8'h01;
         ALU_SUBB: begin
            // Bit 8 of the 9-bit difference and bit 4 of the nibble difference are the borrows.
            sum9  = {1'b0, a_data} - {1'b0, b_data} - {8'h00, c_in};
            nib5  = {1'b0, a_data[3:0]} - {1'b0, b_data[3:0]} - {4'h0, c_in};
            ans_d = sum9[7:0];
            c_d   = sum9[8];
            ac_d  = nib5[4];
            ov_d  = (a_data[7] != b_data[7]) && (sum9[7] != a_data[7]);
         end
         ALU_MUL: begin
            ans_d = prod[7:0];
            b_d   = prod[15:8];
            c_d   = 1'b0;
            ov_d  = |prod[15:8];
         end
         ALU_DIV: begin
            ans_d = quot;
            b_d   = rem;
            c_d   = 1'b0;
            ov_d  = div_zero;
         end
         ALU_DA: begin
            da9 = {1'b0, a_data};
            if (a_data[3:0] > 4'd9 || ac_in) da9 = da9 + 9'h006;
            if (da9[7:4] > 4'd9 || c_in || da9[8]) da9 = da9 + 9'h060;
            ans_d = da9[7:0];
            c_d   = c_in | da9[8];
         end
         ALU_ANL:  ans_d = a_data & b_data;
         ALU_ORL:  ans_d = a_data | b_data;
         ALU_XRL:  ans_d = a_data ^ b_data;
         ALU_CLR:  ans_d = 8'h00;
         ALU_CPLC: begin
            ans_d = a_data;
            c_d   = ~c_in;
         end
         ALU_CPLA: ans_d = ~a_data;
         ALU_RL:   ans_d = {a_data[6:0], a_data[7]};
         ALU_RLC: begin
            ans_d = {a_data[6:0], c_in};
            c_d   = a_data[7];
         end
         ALU_RR:   ans_d = {a_data[0], a_data[7:1]};
         ALU_RRC: begin
            ans_d = {c_in, a_data[7:1]};
            c_d   = a_data[0];
         end
         ALU_SWAP: ans_d = {a_data[3:0], a_data[7:4]};
         default:  ans_d = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers use non-blocking assignments so all outputs update together at the edge.
      if (!rst_n) begin
         ans    <= 8'h00;
         b_out  <= 8'h00;
         c_out  <= 1'b0;
         ac_out <= 1'b0;
         ov_out <= 1'b0;
      end else begin
         ans    <= ans_d;
         b_out  <= b_d;
         c_out  <= c_d;
         ac_out <= ac_d;
         ov_out <= ov_d;
      end
   end
endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu with hand-computed expected values.
module tb_alu;
   import alu_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [7:0]          a_data, b_data;
   logic                c_in, ac_in;
   logic [ALU_OP_W-1:0] alu_op;
   logic [7:0]          ans, b_out;
   logic                c_out, ac_out, ov_out;

   int total = 0;
   int bad   = 0;

   alu dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a_data (a_data),
      .b_data (b_data),
      .c_in   (c_in),
      .ac_in  (ac_in),
      .alu_op (alu_op),
      .ans    (ans),
      .c_out  (c_out),
      .ac_out (ac_out),
      .ov_out (ov_out),
      .b_out  (b_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic step(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic ac);
      alu_op = op;
      a_data = a;
      b_data = b;
      c_in   = c;
      ac_in  = ac;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n  = 1'b0;
      alu_op = ALU_ADD;
      a_data = 8'h45;
      b_data = 8'h26;
      c_in   = 1'b0;
      ac_in  = 1'b0;
      #12;
      check("reset_ans", {8'h00, ans}, 16'h0000);
      rst_n = 1'b1;

      step(ALU_ADD, 8'h45, 8'h26, 1'b0, 1'b0);
      check("add_ans", {8'h00, ans}, 16'h006B);

      // Async reset mid-cycle: outputs must clear with no clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_ans", {8'h00, ans}, 16'h0000);
      check("async_rst_flags", {13'h0, c_out, ac_out, ov_out}, 16'h0000);
      check("async_rst_b", {8'h00, b_out}, 16'h0000);
      #1;
      rst_n = 1'b1;
      step(ALU_ADD, 8'h45, 8'h26, 1'b0, 1'b0);
      check("add_after_rst_ans", {8'h00, ans}, 16'h006B);
      check("add_after_rst_c_ov", {14'h0, c_out, ov_out}, 16'h0000);

      step(ALU_ADD, 8'hF8, 8'h09, 1'b0, 1'b0);
      check("add_carry", {7'h0, c_out, ans}, 16'h0101);
      check("add_ac", {15'h0, ac_out}, 16'h0001);

      step(ALU_ADDC, 8'h75, 8'h78, 1'b1, 1'b0);
      check("addc_ans", {8'h00, ans}, 16'h00EE);
      check("addc_c_ov", {14'h0, c_out, ov_out}, 16'h0001);

      step(ALU_SUBB, 8'h57, 8'h12, 1'b0, 1'b0);
      check("subb_ans", {7'h0, c_out, ans}, 16'h0045);

      step(ALU_SUBB, 8'h10, 8'h20, 1'b1, 1'b0);
      check("subb_borrow", {7'h0, c_out, ans}, 16'h01EF);
      check("subb_ac_ov", {14'h0, ac_out, ov_out}, 16'h0002);

      step(ALU_INC, 8'h12, 8'h00, 1'b0, 1'b0);
      check("inc", {8'h00, ans}, 16'h0013);
      step(ALU_DEC, 8'h32, 8'h00, 1'b0, 1'b0);
      check("dec", {8'h00, ans}, 16'h0031);
      step(ALU_INC, 8'hFF, 8'h00, 1'b1, 1'b0);
      check("inc_wrap", {7'h0, c_out, ans}, 16'h0100);
      step(ALU_DEC, 8'h00, 8'h00, 1'b0, 1'b0);
      check("dec_wrap", {7'h0, c_out, ans}, 16'h00FF);

      step(ALU_MUL, 8'h25, 8'h04, 1'b1, 1'b0);
      check("mul_lo_hi", {b_out, ans}, 16'h0094);
      check("mul_c_ov", {14'h0, c_out, ov_out}, 16'h0000);
      step(ALU_MUL, 8'h50, 8'hA0, 1'b0, 1'b0);
      check("mul_big", {b_out, ans}, 16'h3200);
      check("mul_big_ov", {15'h0, ov_out}, 16'h0001);

      step(ALU_DIV, 8'h90, 8'h0A, 1'b1, 1'b0);
      check("div_q_r", {b_out, ans}, 16'h040E);
      check("div_c_ov", {14'h0, c_out, ov_out}, 16'h0000);
      step(ALU_DIV, 8'h37, 8'h00, 1'b0, 1'b0);
      check("div0_q_r", {b_out, ans}, 16'h37FF);
      check("div0_ov", {15'h0, ov_out}, 16'h0001);

      step(ALU_DA, 8'hBD, 8'h00, 1'b0, 1'b0);
      check("da_ans", {7'h0, c_out, ans}, 16'h0123);
      step(ALU_DA, 8'h12, 8'h00, 1'b1, 1'b1);
      check("da_sticky_c", {7'h0, c_out, ans}, 16'h0178);

      step(ALU_ANL, 8'hF0, 8'hAA, 1'b0, 1'b0);
      check("anl", {8'h00, ans}, 16'h00A0);
      step(ALU_ORL, 8'hF0, 8'hAA, 1'b0, 1'b0);
      check("orl", {8'h00, ans}, 16'h00FA);
      step(ALU_XRL, 8'hF0, 8'hAA, 1'b0, 1'b0);
      check("xrl", {8'h00, ans}, 16'h005A);
      step(ALU_CPLA, 8'hF0, 8'hAA, 1'b0, 1'b0);
      check("cpla", {8'h00, ans}, 16'h000F);
      step(ALU_CLR, 8'hF0, 8'hAA, 1'b0, 1'b0);
      check("clr", {8'h00, ans}, 16'h0000);
      step(ALU_CPLC, 8'hF0, 8'hAA, 1'b0, 1'b1);
      check("cplc", {6'h0, c_out, ac_out, ans}, 16'h03F0);

      step(ALU_RL, 8'hB2, 8'h00, 1'b0, 1'b0);
      check("rl", {7'h0, c_out, ans}, 16'h0065);
      step(ALU_RLC, 8'hB2, 8'h00, 1'b1, 1'b0);
      check("rlc", {7'h0, c_out, ans}, 16'h0165);
      step(ALU_RR, 8'hB2, 8'h00, 1'b1, 1'b0);
      check("rr", {7'h0, c_out, ans}, 16'h0159);
      step(ALU_RRC, 8'hB2, 8'h00, 1'b1, 1'b0);
      check("rrc", {7'h0, c_out, ans}, 16'h00D9);
      step(ALU_SWAP, 8'hB2, 8'h00, 1'b0, 1'b0);
      check("swap", {8'h00, ans}, 16'h002B);

      step(5'd25, 8'hB2, 8'h33, 1'b1, 1'b1);
      check("op25_ans_b", {b_out, ans}, 16'h0000);
      check("op25_flags", {13'h0, c_out, ac_out, ov_out}, 16'h0006);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit arithmetic/logic unit for the 8051-compatible CPU core, decoding a 5-bit operation code (0..18) over accumulator-style operands.
- Produces the result byte, carry, auxiliary carry, overflow, and a secondary byte (B-register result for MUL/DIV).
- Sits between the instruction decoder/register file and the PSW/ACC/B write-back path.
- All outputs are registered: one clock of latency.

Parameters:
- None. Data width is fixed at 8 bits and the opcode width at 5 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- a_data  input  8  operand A (accumulator)
- b_data  input  8  operand B
- c_in  input  1  carry flag in (PSW.CY)
- ac_in  input  1  auxiliary carry in (PSW.AC), used by DA only
- alu_op  input  5  operation select
- ans  output  8  result byte
- c_out  output  1  carry flag out
- ac_out  output  1  auxiliary carry out
- ov_out  output  1  overflow flag out
- b_out  output  8  secondary result (MUL high byte / DIV remainder), else 0x00

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n low clears all outputs immediately: ans=0x00, b_out=0x00, c_out=0, ac_out=0, ov_out=0).
- Otherwise, at every rising clk edge, all outputs load the combinational function of the current inputs. The latency is 1 cycle and there is no handshake.
- Flag default: unless listed below, c_out=c_in, ac_out=ac_in, ov_out=0, and b_out=0x00.
- 0 ADD: {c,ans}=a+b. ac=carry out of bit3. ov=signed overflow.
- 1 ADDC: {c,ans}=a+b+c_in. ac and ov as for ADD.
- 2 INC: ans=a+1, wrapping from 0xFF to 0x00. Carry passes through.
- 3 DEC: ans=a-1, wrapping from 0x00 to 0xFF. Carry passes through.
- 4 SUBB: ans=a-b-c_in. c=1 on borrow. ac=borrow from bit3. ov=signed overflow.
- 5 MUL: 16-bit product. ans=low byte, b_out=high byte. c=0. ov=1 if product>0xFF.
- 6 DIV: ans=a/b, b_out=a%b, c=0, ov=0.
  - b=0: ans=0xFF, b_out=a, ov=1.
- 7 DA: if a[3:0]>9 or ac_in, add 0x06. Then if the high nibble >9 or c_in or that step carried, add 0x60. c is set on carry out of bit 7 and is never cleared.
- 8 ANL: ans=a&b.
- 9 ORL: ans=a|b.
- 10 XRL: ans=a^b.
- 11 CLR: ans=0x00.
- 12 CPL C: ans=a, c=~c_in.
- 13 CPL A: ans=~a.
- 14 RL: ans={a[6:0],a[7]}.
- 15 RLC: ans={a[6:0],c_in}, c=a[7].
- 16 RR: ans={a[0],a[7:1]}.
- 17 RRC: ans={c_in,a[7:1]}, c=a[0].
- 18 SWAP: ans={a[3:0],a[7:4]}.
- Opcodes 19..31: ans=0x00, with flags at their defaults.
- Operands are treated as unsigned except for the ov computation, which treats them as two's complement.

Decomposition:
- Shared package alu_pkg holds the localparams for the 19 opcodes (ALU_ADD=0 … ALU_SWAP=18) and the 5-bit width constant; the decoder also uses this package.
- One natural sub-module is alu_muldiv, a combinational 8x8 multiply and 8/8 divide with the divide-by-zero rule. The remainder of the block is a single case statement feeding the output registers.

Test Plan:
- Reset: hold rst_n=0 mid-operation with op ADD, a=0x45, b=0x26 -> all outputs are 0 immediately with no clock edge. Release rst_n, then one clk -> ans=0x6B, c_out=0, ov=0.
- Arithmetic:
  - ADDC a=0x75, b=0x78, c_in=1 -> ans=0xEE, c=0, ov=1.
  - SUBB a=0x57, b=0x12, c_in=0 -> ans=0x45, c=0.
  - INC 0x12 -> 0x13.
  - DEC 0x32 -> 0x31.
  - INC 0xFF -> 0x00 with c unchanged.
- MUL/DIV:
  - MUL 0x25*0x04 -> ans=0x94, b_out=0x00, ov=0.
  - DIV 0x90/0x0A -> ans=0x0E, b_out=0x04.
  - DIV by 0x00 -> ans=0xFF, ov=1.
- DA: a=0xBD, c_in=0, ac_in=0 -> ans=0x23, c_out=1.
- Logic: a=0xF0, b=0xAA.
  - ANL -> 0xA0.
  - ORL -> 0xFA.
  - XRL -> 0x5A.
  - CPL A -> 0x0F.
  - CLR -> 0x00.
  - CPL C with c_in=0 -> c_out=1.
- Rotates/swap: a=0xB2.
  - RL -> 0x65.
  - RLC with c_in=1 -> 0x65, c=1.
  - RR -> 0x59.
  - RRC with c_in=1 -> 0xD9, c=0.
  - SWAP -> 0x2B.
  - Opcode 25 -> ans=0x00.
